// File: rtl/path_tracer.sv
// Walks the predecessor RAM from a destination back to the source, stacks the
// nodes in a LIFO, then streams the path source-first over valid/ready.
module path_tracer #(
    parameter int NODE_WIDTH = 5,
    parameter int MAX_NODES  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NODE_WIDTH-1:0] src_node,
    input  logic [NODE_WIDTH-1:0] dst_node,
    output logic [NODE_WIDTH-1:0] mem_addr,
    input  logic [NODE_WIDTH-1:0] mem_q,
    output logic                  busy,
    output logic                  path_valid,
    input  logic                  path_ready,
    output logic [NODE_WIDTH-1:0] path_node,
    output logic                  path_last,
    output logic                  done,
    output logic                  error
);

    // state  | meaning
    // IDLE   | waiting for start
    // READ   | mem_addr = cur, predecessor arrives next cycle
    // CHECK  | judge mem_q: self-pointer, hop limit, source reached
    // EMIT   | stream LIFO top, pop on handshake
    // FINISH | done pulse
    // FAIL   | error pulse, LIFO discarded

    localparam int CNT_W = $clog2(MAX_NODES) + 1;
    localparam logic [CNT_W-1:0] HOP_LIMIT = CNT_W'(MAX_NODES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_EMIT,
        S_FINISH,
        S_FAIL
    } state_t;

    state_t state, state_next;

    logic [NODE_WIDTH-1:0] src_q;
    logic [NODE_WIDTH-1:0] cur;
    logic [NODE_WIDTH-1:0] addr_hold;
    logic [CNT_W-1:0]      hop_cnt;
    logic [CNT_W-1:0]      ptr;
    logic [NODE_WIDTH-1:0] lifo [MAX_NODES];

    logic                  latch;
    logic                  push;
    logic                  pop;
    logic                  clear;
    logic                  hop_clr;
    logic                  hop_inc;
    logic                  cur_load;
    logic [NODE_WIDTH-1:0] push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        hop_clr    = 1'b0;
        hop_inc    = 1'b0;
        cur_load   = 1'b0;
        push_data  = dst_node;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    latch    = 1'b1;
                    push     = 1'b1;
                    cur_load = 1'b1;
                    hop_clr  = 1'b1;
                    state_next = (dst_node == src_node) ? S_EMIT : S_READ;
                end
            end
            S_READ: begin
                hop_inc    = 1'b1;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                push_data = mem_q;
                if (mem_q == cur) begin
                    state_next = S_FAIL;
                end else if (hop_cnt == HOP_LIMIT && mem_q != src_q) begin
                    state_next = S_FAIL;
                end else begin
                    push     = 1'b1;
                    cur_load = 1'b1;
                    state_next = (mem_q == src_q) ? S_EMIT : S_READ;
                end
            end
            S_EMIT: begin
                if (path_ready) begin
                    pop = 1'b1;
                    if (ptr == CNT_W'(1)) begin
                        state_next = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            S_FAIL: begin
                clear      = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            cur       <= '0;
            addr_hold <= '0;
            hop_cnt   <= '0;
            ptr       <= '0;
        end else begin
            if (latch) begin
                src_q <= src_node;
            end
            if (cur_load) begin
                cur <= push_data;
            end
            if (hop_clr) begin
                hop_cnt <= '0;
            end else if (hop_inc) begin
                hop_cnt <= hop_cnt + CNT_W'(1);
            end
            if (clear) begin
                ptr <= '0;
            end else if (push) begin
                ptr <= ptr + CNT_W'(1);
            end else if (pop) begin
                ptr <= ptr - CNT_W'(1);
            end
            if (state == S_READ) begin
                addr_hold <= cur;
            end
        end
    end

    // Storage needs no reset: only entries below ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            lifo[NODE_WIDTH'(ptr)] <= push_data;
        end
    end

    always_comb begin
        mem_addr   = (state == S_READ) ? cur : addr_hold;
        busy       = (state != S_IDLE);
        path_valid = (state == S_EMIT);
        path_node  = '0;
        path_last  = 1'b0;
        if (state == S_EMIT) begin
            path_node = lifo[NODE_WIDTH'(ptr - CNT_W'(1))];
            path_last = (ptr == CNT_W'(1));
        end
        done  = (state == S_FINISH);
        error = (state == S_FAIL);
    end

endmodule

// File: tb/tb_path_tracer.sv
// Scoreboard bench for path_tracer: a predecessor-chain reference model fills
// expected beat/event queues; a negedge monitor pops and compares.
module tb_path_tracer;

    localparam int NW   = 5;
    localparam int MAXN = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] src_node;
    logic [NW-1:0] dst_node;
    logic [NW-1:0] mem_addr;
    logic [NW-1:0] mem_q;
    logic          busy;
    logic          path_valid;
    logic          path_ready;
    logic [NW-1:0] path_node;
    logic          path_last;
    logic          done;
    logic          error;

    path_tracer #(.NODE_WIDTH(NW), .MAX_NODES(MAXN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_node(src_node),
        .dst_node(dst_node), .mem_addr(mem_addr), .mem_q(mem_q), .busy(busy),
        .path_valid(path_valid), .path_ready(path_ready), .path_node(path_node),
        .path_last(path_last), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [NW-1:0] prev_mem [MAXN];
    always @(posedge clk) mem_q <= prev_mem[mem_addr];

    typedef struct {
        logic [NW-1:0] node;
        logic          last;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_evts[$];   // 1 = done, 2 = error
    int    exp_lat;
    int    n_vec = 0;
    int    n_err = 0;
    int    ready_mode = 0; // 0 always, 1 pattern 1,0,0, 2 random, 3 never

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: follow predecessors from dst; the path exists iff src is
    // reached within MAXN-1 steps without meeting a self-pointer.
    task automatic model(input int s, input int d);
        int chain[$];
        int cur, p, hops;
        bit bad;
        chain.push_back(d);
        bad  = 0;
        hops = 0;
        cur  = d;
        if (d != s) begin
            for (int h = 1; h <= MAXN - 1; h++) begin
                p    = int'(prev_mem[cur]);
                hops = h;
                if (p == cur || (h == MAXN - 1 && p != s)) begin
                    bad = 1;
                    break;
                end
                chain.push_back(p);
                if (p == s) break;
                cur = p;
            end
        end
        exp_lat = 2 * hops + 1;
        if (bad) begin
            exp_evts.push_back(2);
        end else begin
            for (int i = chain.size() - 1; i >= 0; i--) begin
                beat_t b;
                b.node = NW'(chain[i]);
                b.last = (i == 0);
                exp_beats.push_back(b);
            end
            exp_evts.push_back(1);
        end
    endtask

    initial begin : ready_driver
        int pat = 0;
        path_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       path_ready = 1'b1;
                1:       path_ready = (pat % 3 == 0);
                2:       path_ready = ($urandom_range(0, 1) == 1);
                default: path_ready = 1'b0;
            endcase
            pat++;
        end
    end

    initial begin : monitor
        int    mon_cyc = 0;
        int    hs_cyc = -10;
        bit    stall = 0;
        logic [NW-1:0] stall_node;
        logic  stall_last;
        beat_t b;
        int    e;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!rst_n) begin
                stall = 0;
                continue;
            end
            if (stall) begin
                check("stall_valid_held", 32'(path_valid), 1);
                check("stall_node_stable", 32'(path_node), 32'(stall_node));
                check("stall_last_stable", 32'(path_last), 32'(stall_last));
            end
            if (path_valid && path_ready) begin
                if (exp_beats.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got node %0d, expected no beat", path_node);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_node", 32'(path_node), 32'(b.node));
                    check("beat_last", 32'(path_last), 32'(b.last));
                    if (path_last) hs_cyc = mon_cyc;
                end
            end
            stall      = path_valid && !path_ready;
            stall_node = path_node;
            stall_last = path_last;
            if (done || error) begin
                if (exp_evts.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got done=%0d error=%0d, expected none", done, error);
                end else begin
                    e = exp_evts.pop_front();
                    check("event_kind", done ? 1 : 2, 32'(e));
                    check("event_exclusive", 32'(done & error), 0);
                    if (done) check("done_delay", 32'(mon_cyc - hs_cyc), 1);
                end
            end
        end
    end

    task automatic run_case(input int s, input int d, input bit inject);
        int cyc, n;
        model(s, d);
        src_node = NW'(s);
        dst_node = NW'(d);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        cyc = 1;
        while (!(path_valid || error) && cyc < 200) begin
            start    = inject && (cyc == 10);
            src_node = (inject && cyc == 10) ? NW'(d) : NW'(s);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("first_response_latency", 32'(cyc), 32'(exp_lat));
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_released", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        check("beats_outstanding", 32'(exp_beats.size()), 0);
        check("events_outstanding", 32'(exp_evts.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_chain3();
        prev_mem[9] = 5'd4;
        prev_mem[4] = 5'd7;
        prev_mem[7] = 5'd0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int perm[MAXN];
        int len, k, j, tmp, n;
        rst_n = 1'b0;
        start = 1'b0;
        src_node = '0;
        dst_node = '0;
        for (int i = 0; i < MAXN; i++) prev_mem[i] = NW'($urandom_range(0, MAXN - 1));
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(path_valid), 0);
        check("reset_outputs", 32'({path_node, path_last, done, error, mem_addr}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_case(3, 3, 0);
        set_chain3();
        run_case(0, 9, 0);
        ready_mode = 1;
        run_case(0, 9, 0);
        ready_mode = 0;
        prev_mem[12] = 5'd12;
        run_case(0, 12, 0);
        prev_mem[1] = 5'd2;
        prev_mem[2] = 5'd1;
        run_case(0, 1, 1);

        // Abort mid-EMIT with reset, then rerun the same chain.
        set_chain3();
        ready_mode = 3;
        @(posedge clk);
        #1;
        src_node = 5'd0;
        dst_node = 5'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!path_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reached_emit", 32'(path_valid), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(path_valid), 0);
        check("abort_outputs", 32'({path_node, path_last, done, error, mem_addr}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        run_case(0, 9, 0);

        // Longest legal path: all MAXN nodes.
        for (int i = 0; i < MAXN; i++) perm[i] = i;
        for (int i = MAXN - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 1; i < MAXN; i++) prev_mem[perm[i]] = NW'(perm[i-1]);
        run_case(perm[0], perm[MAXN-1], 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < MAXN; i++) begin
                perm[i] = i;
                prev_mem[i] = NW'($urandom_range(0, MAXN - 1));
            end
            for (int i = MAXN - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            len = $urandom_range(1, MAXN);
            for (int i = 1; i < len; i++) prev_mem[perm[i]] = NW'(perm[i-1]);
            if (len > 1 && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, len - 1);
                prev_mem[perm[k]] = NW'(perm[$urandom_range(k, len - 1)]);
            end
            ready_mode = $urandom_range(0, 2);
            run_case(perm[0], perm[len-1], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/path_tracer.md
# path_tracer

Path reconstruction reader for the predecessor RAM. After the Dijkstra relaxation engine has written each node's predecessor into `previous_memory`, this block walks the chain from a destination node back to the source through one read port, stacking nodes in an internal LIFO. It then streams the path source-first over a valid/ready interface to the display/UART stage. It never writes the RAM; the integrator ties that port's write enable low.

## Interface
- `NODE_WIDTH`, 5: node index width; equals predecessor RAM data and address width.
- `MAX_NODES`, 32: node count, 2**NODE_WIDTH; LIFO depth and hop limit.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `src_node`  in  NODE_WIDTH  search source; latched on accepted start.
- `dst_node`  in  NODE_WIDTH  path destination; latched on accepted start.
- `mem_addr`  out  NODE_WIDTH  predecessor RAM read address.
- `mem_q`  in  NODE_WIDTH  predecessor RAM read data; registered, 1-cycle latency.
- `busy`  out  1  high from the cycle after an accepted start until return to IDLE.
- `path_valid`  out  1  path_node is valid.
- `path_ready`  in  1  consumer accepts when high together with path_valid.
- `path_node`  out  NODE_WIDTH  path element, source first.
- `path_last`  out  1  marks the destination element.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  one-cycle pulse on an unreachable or corrupt chain.

## Operation
- Reset values: every output is 0. FSM is IDLE, LIFO pointer is 0, hop counter is 0.
- States: IDLE, READ, CHECK, EMIT, FINISH, FAIL.
- IDLE:
  - On `start`, latch src and dst, set cur = dst, push dst, clear the hop counter.
  - If dst == src, go to EMIT; otherwise go to READ.
  - `start` in any other state is ignored.
- READ:
  - Drive mem_addr = cur; increment the hop counter; go to CHECK.
- CHECK (mem_q is the predecessor of cur):
  - mem_q == cur: self-pointer, meaning the node is unreachable. Go to FAIL.
  - Hop counter == MAX_NODES−1 and mem_q != src: the chain is cyclic. Go to FAIL.
  - Otherwise push mem_q and set cur = mem_q.
  - If mem_q == src, go to EMIT; else go to READ.
- EMIT:
  - path_node = LIFO top, path_valid = 1, path_last = (pointer == 1).
  - On a valid&&ready handshake, pop.
  - A handshake on the last element goes to FINISH.
  - Outputs stay stable while path_valid && !path_ready.
- FINISH: pulse `done`, go to IDLE.
- FAIL: pulse `error`, clear the LIFO without emitting, go to IDLE.
- LIFO holds at most MAX_NODES entries, reached only on a MAX_NODES-node path. Overflow cannot occur given the hop limit.
- mem_addr holds its last value outside READ.
- Comparisons are unsigned on NODE_WIDTH bits. The hop counter is $clog2(MAX_NODES)+1 bits wide, so it does not wrap.

## Timing
- Start to first READ: 1 cycle (accept edge, then READ).
- Each hop takes 2 cycles (READ, CHECK).
- A path of N nodes (N−1 hops) produces first path_valid 2(N−1)+1 cycles after the start edge. For dst == src, the delay is 1 cycle.
- With path_ready held high, one element transfers per cycle.
- `done` is asserted in the cycle after the final handshake. `busy` drops in the cycle after `done`.
- `error` is asserted in the cycle after the failing CHECK.
- `rst_n` asserted mid-operation (including mid-EMIT) forces IDLE immediately. Outputs go to 0 and the LIFO empties. No `done` or `error` is produced.
- The requester must not change RAM contents while `busy`; the block does not check for this.

## Test plan
- Trivial path: src=3, dst=3, path_ready=1 → single beat path_node=3, path_last=1, first valid 1 cycle after start, then `done`.
- Three-hop chain: prev[9]=4, prev[4]=7, prev[7]=0, src=0, dst=9 → beats 0,7,4,9 with last on 9; first valid at cycle 7 after start; `done` one cycle after the 9 handshake.
- Backpressure: same chain with path_ready toggling 1,0,0,1,... → no element lost or duplicated; path_node and path_last stable during stalls.
- Unreachable: prev[12]=12, src=0, dst=12 → `error` pulse 3 cycles after start, no path_valid, busy low afterward.
- Cycle guard: prev[1]=2, prev[2]=1, src=0, dst=1, MAX_NODES=32 → `error` after 31 hops (62 cycles of READ/CHECK), no path_valid. A `start` pulse during the walk is ignored.
- Reset mid-EMIT: deassert path_ready during the three-hop emission, pulse rst_n low → all outputs 0 on assertion; a new start then produces the full correct path.
